fir_mac_sequencer: RTL and testbench

//  Time-multiplexed FIR controller for the low-pass channel-strip stage. It owns an
//  L-deep circular sample store, sequences one shared multiply-accumulate across all

---
 rtl/fir_mac_sequencer.sv | 137 +++++++++++++
 tb/tb_fir_mac_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR: one shared MAC walks all L taps per accepted sample,
// newest sample first, then rounds, saturates and strobes a 16-bit result.
module fir_mac_sequencer #(
   parameter int L     = 5,
   parameter int CW    = 16,
   parameter int ACCW  = 40,
   parameter int SHIFT = 15
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   sample_valid,
   input  logic signed [15:0]     sample_in,
   output logic [$clog2(L)-1:0]   coef_addr,
   input  logic signed [CW-1:0]   coef_data,
   output logic signed [15:0]     filt_out,
   output logic                   filt_valid,
   output logic                   busy,
   output logic                   overrun,
   input  logic                   overrun_clr
);

   localparam int AW = $clog2(L);
   localparam int PW = 16 + CW;
   localparam logic signed [ACCW-1:0] HALF    = ACCW'(1) << (SHIFT - 1);
   localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'(32767);
   localparam logic signed [ACCW-1:0] SAT_MIN = ACCW'(-32768);

   typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

   state_t                 state_reg, state_next;
   logic [AW-1:0]          wr_ptr_reg, k_reg;
   logic signed [ACCW-1:0] acc_reg;
   logic signed [15:0]     store_reg [L];
   logic signed [15:0]     filt_out_reg;
   logic                   filt_valid_reg, overrun_reg;

   logic                   accept;
   logic [L-1:0]           wr_en;
   logic [AW:0]            rd_sum;
   logic [AW-1:0]          rd_idx;
   logic signed [15:0]     tap;
   logic signed [PW-1:0]   prod;
   logic signed [ACCW-1:0] acc_next, rnd, shifted;
   logic signed [15:0]     sat_val;

   assign accept = (state_reg == IDLE) && sample_valid;

   // One write-enable per store slot; only the slot at wr_ptr takes the sample.
   for (genvar gi = 0; gi < L; gi++) begin : g_wr_en
      assign wr_en[gi] = accept && (wr_ptr_reg == AW'(gi));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < L; i++) store_reg[i] <= '0;
      end else begin
         for (int i = 0; i < L; i++)
            if (wr_en[i]) store_reg[i] <= sample_in;
      end
   end

   // Newest-first tap: (wr_ptr - k) mod L without a divider.
   always_comb begin
      rd_sum = {1'b0, wr_ptr_reg} + (AW+1)'(L) - {1'b0, k_reg};
      rd_idx = (rd_sum >= (AW+1)'(L)) ? AW'(rd_sum - (AW+1)'(L)) : AW'(rd_sum);
   end

   assign tap      = store_reg[rd_idx];
   assign prod     = tap * coef_data;
   assign acc_next = acc_reg + {{(ACCW-PW){prod[PW-1]}}, prod};
   assign rnd      = acc_reg + HALF;
   assign shifted  = rnd >>> SHIFT;

   always_comb begin
      if (shifted > SAT_MAX)      sat_val = 16'sh7FFF;
      else if (shifted < SAT_MIN) sat_val = -16'sh8000;
      else                        sat_val = shifted[15:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (sample_valid) state_next = MAC;
         MAC:     if (k_reg == AW'(L - 1)) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy      = (state_reg != IDLE);
      coef_addr = (state_reg == MAC) ? k_reg : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg     <= '0;
         k_reg          <= '0;
         acc_reg        <= '0;
         filt_out_reg   <= '0;
         filt_valid_reg <= 1'b0;
         overrun_reg    <= 1'b0;
      end else begin
         filt_valid_reg <= (state_reg == DONE);
         // A dropped sample outranks a coincident clear.
         if (sample_valid && state_reg != IDLE) overrun_reg <= 1'b1;
         else if (overrun_clr)                   overrun_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (sample_valid) begin
                  acc_reg <= '0;
                  k_reg   <= '0;
               end
            end
            MAC: begin
               acc_reg <= acc_next;
               if (k_reg != AW'(L - 1)) k_reg <= k_reg + AW'(1);
            end
            DONE: begin
               filt_out_reg <= sat_val;
               wr_ptr_reg   <= (wr_ptr_reg == AW'(L - 1)) ? '0 : wr_ptr_reg + AW'(1);
            end
            default: ;
         endcase
      end
   end

   assign filt_out   = filt_out_reg;
   assign filt_valid = filt_valid_reg;
   assign overrun    = overrun_reg;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer: a plain shift-register FIR model feeds
// a scoreboard queue of expected results and strobe cycles.
module tb_fir_mac_sequencer;

   localparam int L     = 5;
   localparam int CW    = 16;
   localparam int ACCW  = 40;
   localparam int SHIFT = 15;
   localparam int AW    = $clog2(L);

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 sample_valid = 1'b0;
   logic                 overrun_clr = 1'b0;
   logic signed [15:0]   sample_in = '0;
   logic [AW-1:0]        coef_addr;
   logic signed [CW-1:0] coef_data;
   logic signed [15:0]   filt_out;
   logic                 filt_valid, busy, overrun;

   logic signed [CW-1:0] coef [L];
   assign coef_data = coef[coef_addr];

   fir_mac_sequencer #(.L(L), .CW(CW), .ACCW(ACCW), .SHIFT(SHIFT)) dut (
      .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_in(sample_in),
      .coef_addr(coef_addr), .coef_data(coef_data), .filt_out(filt_out),
      .filt_valid(filt_valid), .busy(busy), .overrun(overrun),
      .overrun_clr(overrun_clr)
   );

   always #5 clk = ~clk;

   typedef struct { int val; int cyc; } exp_t;
   exp_t sbq [$];
   int   hist [L];
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;
   int   nres = 0;

   function automatic int model_out();
      longint acc = 0;
      for (int k = 0; k < L; k++) acc += longint'(hist[k]) * longint'(coef[k]);
      acc = (acc + (longint'(1) << (SHIFT - 1))) >>> SHIFT;
      if (acc > 32767)  acc = 32767;
      if (acc < -32768) acc = -32768;
      return int'(acc);
   endfunction

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: got %0d, expected %0d", tag, obs, expv);
      end
   endtask

   task automatic tick();
      exp_t e;
      @(negedge clk);
      cyc++;
      if (filt_valid === 1'b1) begin
         if (sbq.size() == 0) begin
            chk("spurious filt_valid", filt_valid, 0);
         end else begin
            e = sbq.pop_front();
            nres++;
            $display("result %0d: filt_out=%0d expected=%0d cycle=%0d", nres, filt_out, e.val, cyc);
            chk("filt_out", filt_out, e.val);
            chk("latency", cyc, e.cyc);
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic send(input int s);
      sample_in    = 16'(s);
      sample_valid = 1'b1;
      for (int k = L - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = s;
      sbq.push_back('{model_out(), cyc + L + 2});
      tick();
      sample_valid = 1'b0;
   endtask

   task automatic send_spaced(input int s, input int gap);
      send(s);
      idle(gap - 1);
   endtask

   task automatic pulse_drop(input int s);
      sample_in    = 16'(s);
      sample_valid = 1'b1;
      tick();
      sample_valid = 1'b0;
   endtask

   task automatic set_coefs(input int c);
      for (int k = 0; k < L; k++) coef[k] = 16'(c);
   endtask

   initial begin
      for (int k = 0; k < L; k++) hist[k] = 0;
      set_coefs(16'h4000);

      // Reset state
      idle(2);
      chk("reset busy", busy, 0);
      chk("reset filt_valid", filt_valid, 0);
      chk("reset filt_out", filt_out, 0);
      chk("reset overrun", overrun, 0);
      chk("reset coef_addr", coef_addr, 0);
      rst = 1'b0;
      idle(2);

      // Impulse with MAC-cycle address walk
      send(1000);
      chk("mac busy", busy, 1);
      chk("coef_addr k0", coef_addr, 0);
      for (int k = 1; k < L; k++) begin
         tick();
         chk("coef_addr walk", coef_addr, k);
      end
      tick();
      chk("done busy", busy, 1);
      chk("done coef_addr", coef_addr, 0);
      idle(3);
      for (int i = 0; i < 6; i++) send_spaced(0, L + 4);

      // Tap order, newest first, across wr_ptr wrap
      for (int k = 0; k < L; k++) coef[k] = 16'(k * 16'h1000);
      send_spaced(8, L + 2);
      for (int i = 0; i < 4; i++) send_spaced(0, L + 2);
      idle(3);
      chk("hold filt_out", filt_out, 4);
      chk("hold filt_valid", filt_valid, 0);
      send_spaced(0, L + 2);

      // Rounding: acc 0x4000 -> 1
      set_coefs(16'h4000);
      send_spaced(1, L + 2);
      send_spaced(-1, L + 2);
      for (int i = 0; i < L; i++) send_spaced(0, L + 2);

      // Saturation both ways
      set_coefs(16'h7FFF);
      for (int i = 0; i < L + 1; i++) send_spaced(32767, L + 2);
      for (int i = 0; i < L + 1; i++) send_spaced(-32768, L + 2);
      idle(2);
      chk("sat low held", filt_out, -32768);

      // Overrun: dropped pulse two cycles after an accepted sample
      send(100);
      tick();
      pulse_drop(555);
      chk("overrun set", overrun, 1);
      idle(6);
      send_spaced(0, L + 2);
      send_spaced(0, L + 2);
      chk("overrun sticky", overrun, 1);
      overrun_clr = 1'b1;
      tick();
      overrun_clr = 1'b0;
      chk("overrun cleared", overrun, 0);
      send(7);
      tick();
      sample_valid = 1'b1;
      overrun_clr  = 1'b1;
      tick();
      sample_valid = 1'b0;
      overrun_clr  = 1'b0;
      chk("overrun set wins", overrun, 1);
      idle(6);
      overrun_clr = 1'b1;
      tick();
      overrun_clr = 1'b0;
      chk("overrun cleared 2", overrun, 0);

      // Reset during MAC cycle 2
      send(1000);
      tick();
      rst = 1'b1;
      #1;
      chk("midrst busy", busy, 0);
      chk("midrst filt_valid", filt_valid, 0);
      chk("midrst filt_out", filt_out, 0);
      chk("midrst coef_addr", coef_addr, 0);
      chk("midrst overrun", overrun, 0);
      sbq.delete();
      for (int k = 0; k < L; k++) hist[k] = 0;
      idle(2);
      rst = 1'b0;
      idle(L + 4);
      set_coefs(16'h4000);
      send_spaced(1000, L + 4);
      for (int i = 0; i < L; i++) send_spaced(0, L + 4);

      // Back-to-back random stream with random coefficients
      for (int k = 0; k < L; k++) coef[k] = 16'($urandom_range(0, 65535));
      for (int i = 0; i < 50; i++)
         send_spaced(int'($urandom_range(0, 65535)) - 32768, L + 2);
      idle(L + 6);
      chk("b2b no overrun", overrun, 0);
      chk("scoreboard drained", sbq.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
